// File: rtl/window_fetcher_if.sv
// Bundle of the window_fetcher handshake channels: frame start, address issue,
// memory return, pixel output and window position.
interface window_fetcher_if #(
   parameter int W_DATA        = 8,
   parameter int IMG_WIDTH     = 41,
   parameter int IMG_HEIGHT    = 50,
   parameter int PARALLEL_ROWS = 1
);
   localparam int W_ADDR = $clog2(IMG_WIDTH * IMG_HEIGHT);
   localparam int W_X    = $clog2(IMG_WIDTH);
   localparam int W_Y    = $clog2(IMG_HEIGHT);

   logic                              start_valid;
   logic                              start_ready;
   logic [W_X:0]                      start_img_w;
   logic [W_Y:0]                      start_img_h;
   logic [7:0]                        start_scale;
   logic                              addr_valid;
   logic                              addr_ready;
   logic [PARALLEL_ROWS*W_ADDR-1:0]   addr;
   logic                              din_valid;
   logic                              din_ready;
   logic [PARALLEL_ROWS*W_DATA-1:0]   din_data;
   logic                              dout_valid;
   logic                              dout_ready;
   logic [PARALLEL_ROWS*W_DATA-1:0]   dout_data;
   logic [1:0]                        dout_eot;
   logic                              window_pos_valid;
   logic                              window_pos_ready;
   logic                              window_pos_eot;
   logic [7:0]                        window_pos_scale;
   logic [W_X-1:0]                    window_pos_x;
   logic [W_Y-1:0]                    window_pos_y;
   logic                              done;
   logic                              busy;

   modport master (
      input  start_valid, start_img_w, start_img_h, start_scale,
      output start_ready,
      output addr_valid, addr,
      input  addr_ready,
      input  din_valid, din_data,
      output din_ready,
      output dout_valid, dout_data, dout_eot,
      input  dout_ready,
      output window_pos_valid, window_pos_eot, window_pos_scale, window_pos_x, window_pos_y,
      input  window_pos_ready,
      output done, busy
   );

   modport slave (
      output start_valid, start_img_w, start_img_h, start_scale,
      input  start_ready,
      input  addr_valid, addr,
      output addr_ready,
      output din_valid, din_data,
      input  din_ready,
      input  dout_valid, dout_data, dout_eot,
      output dout_ready,
      input  window_pos_valid, window_pos_eot, window_pos_scale, window_pos_x, window_pos_y,
      output window_pos_ready,
      input  done, busy
   );
endinterface

// File: rtl/window_fetcher.sv
// Sweeps a feature window over an image in memory, issuing PARALLEL_ROWS row
// addresses per beat under a credit limit and tagging the returned pixels.
module window_fetcher #(
   parameter int W_DATA          = 8,
   parameter int IMG_WIDTH       = 41,
   parameter int IMG_HEIGHT      = 50,
   parameter int FEATURE_WIDTH   = 24,
   parameter int FEATURE_HEIGHT  = 24,
   parameter int PARALLEL_ROWS   = 1,
   parameter int X_STEP          = 1,
   parameter int Y_STEP          = 1,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic             clk,
   input logic             rst,
   window_fetcher_if.master bus
);
   localparam int W_ADDR   = $clog2(IMG_WIDTH * IMG_HEIGHT);
   localparam int W_X      = $clog2(IMG_WIDTH);
   localparam int W_Y      = $clog2(IMG_HEIGHT);
   localparam int N_GROUPS = FEATURE_HEIGHT / PARALLEL_ROWS;
   localparam int W_C      = (FEATURE_WIDTH > 1) ? $clog2(FEATURE_WIDTH) : 1;
   localparam int W_G      = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
   localparam int W_CR     = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WIN_POS = 2'd1;
   localparam logic [1:0] FETCH   = 2'd2;
   localparam logic [1:0] DRAIN   = 2'd3;

   logic [1:0]                      state;
   logic [W_X:0]                    img_w;
   logic [W_Y:0]                    img_h;
   logic [7:0]                      scale;
   logic [W_X-1:0]                  x0;
   logic [W_Y-1:0]                  y0;
   logic [W_C-1:0]                  c, c_n, c_r;
   logic [W_G-1:0]                  g, g_n, g_r;
   logic [W_CR-1:0]                 credit;
   logic [PARALLEL_ROWS*W_ADDR-1:0] addr_q;
   logic                            done_q;
   logic                            addr_hs, din_hs, fits_x, fits_y, last_win, last_beat;

   function automatic logic [PARALLEL_ROWS*W_ADDR-1:0] beat_addr(input int unsigned x,
                                                                 input int unsigned y);
      logic [PARALLEL_ROWS*W_ADDR-1:0] v;
      int unsigned a;
      v = '0;
      for (int unsigned r = 0; r < PARALLEL_ROWS; r++) begin
         a = (y + r) * IMG_WIDTH + x;
         v[r*W_ADDR +: W_ADDR] = a[W_ADDR-1:0];
      end
      return v;
   endfunction

   always_comb begin
      addr_hs   = bus.addr_valid & bus.addr_ready;
      din_hs    = bus.din_valid & bus.din_ready;
      fits_x    = (32'(x0) + X_STEP + FEATURE_WIDTH) <= 32'(img_w);
      fits_y    = (32'(y0) + Y_STEP + FEATURE_HEIGHT) <= 32'(img_h);
      last_win  = !fits_x && !fits_y;
      last_beat = (c == W_C'(FEATURE_WIDTH - 1)) && (g == W_G'(N_GROUPS - 1));
      if (c == W_C'(FEATURE_WIDTH - 1)) begin
         c_n = '0;
         g_n = g + W_G'(1);
      end else begin
         c_n = c + W_C'(1);
         g_n = g;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         img_w  <= '0;
         img_h  <= '0;
         scale  <= '0;
         x0     <= '0;
         y0     <= '0;
         c      <= '0;
         g      <= '0;
         addr_q <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (bus.start_valid) begin
               img_w <= bus.start_img_w;
               img_h <= bus.start_img_h;
               scale <= bus.start_scale;
               x0    <= '0;
               y0    <= '0;
               if (32'(bus.start_img_w) < FEATURE_WIDTH || 32'(bus.start_img_h) < FEATURE_HEIGHT)
                  done_q <= 1'b1;
               else
                  state <= WIN_POS;
            end
            WIN_POS: if (bus.window_pos_ready) begin
               state  <= FETCH;
               c      <= '0;
               g      <= '0;
               addr_q <= beat_addr(32'(x0), 32'(y0));
            end
            FETCH: if (addr_hs) begin
               if (last_beat) begin
                  if (last_win) begin
                     state <= DRAIN;
                  end else begin
                     if (fits_x) begin
                        x0 <= x0 + W_X'(X_STEP);
                     end else begin
                        x0 <= '0;
                        y0 <= y0 + W_Y'(Y_STEP);
                     end
                     state <= WIN_POS;
                  end
               end else begin
                  // Address for the next beat is precomputed so addr stays a register.
                  c      <= c_n;
                  g      <= g_n;
                  addr_q <= beat_addr(32'(x0) + 32'(c_n), 32'(y0) + 32'(g_n) * PARALLEL_ROWS);
               end
            end
            DRAIN: if (credit == '0) begin
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Credit and return tagging run independently of the issue FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit <= '0;
         c_r    <= '0;
         g_r    <= '0;
      end else begin
         if (addr_hs && !din_hs)
            credit <= credit + W_CR'(1);
         else if (din_hs && !addr_hs)
            credit <= credit - W_CR'(1);
         if (din_hs) begin
            if (c_r == W_C'(FEATURE_WIDTH - 1)) begin
               c_r <= '0;
               g_r <= (g_r == W_G'(N_GROUPS - 1)) ? '0 : g_r + W_G'(1);
            end else begin
               c_r <= c_r + W_C'(1);
            end
         end
      end
   end

   assign bus.start_ready      = (state == IDLE);
   assign bus.busy             = (state != IDLE);
   assign bus.addr_valid       = (state == FETCH) && (32'(credit) < MAX_OUTSTANDING);
   assign bus.addr             = addr_q;
   assign bus.window_pos_valid = (state == WIN_POS);
   assign bus.window_pos_eot   = last_win;
   assign bus.window_pos_scale = scale;
   assign bus.window_pos_x     = x0;
   assign bus.window_pos_y     = y0;
   assign bus.din_ready        = bus.dout_ready & (credit != '0);
   assign bus.dout_valid       = bus.din_valid & (credit != '0);
   assign bus.dout_data        = bus.din_data;
   assign bus.dout_eot[0]      = (c_r == W_C'(FEATURE_WIDTH - 1));
   assign bus.dout_eot[1]      = (c_r == W_C'(FEATURE_WIDTH - 1)) && (g_r == W_G'(N_GROUPS - 1));
   assign bus.done             = done_q;
endmodule

// File: doc/window_fetcher.md
Name: window_fetcher

Overview:
- Parametrised successor of the detector's data-fetch path. Sweeps a FEATURE_WIDTH x FEATURE_HEIGHT window over an image held in memory, at a runtime-selectable image size (per-scale) and a configurable stride.
- Issues PARALLEL_ROWS memory addresses per beat and limits in-flight reads with a credit counter.
- Forwards returned pixels with end-of-row-group and end-of-window tags, and emits the window position and scale to the classifier.

Parameters:
W_DATA, 8, pixel width
IMG_WIDTH, 41, max image width and memory row stride
IMG_HEIGHT, 50, max image height
FEATURE_WIDTH, 24, window width
FEATURE_HEIGHT, 24, window height; must be a multiple of PARALLEL_ROWS
PARALLEL_ROWS, 1, rows fetched per beat (memory lanes)
X_STEP, 1, horizontal window stride (>=1)
Y_STEP, 1, vertical window stride (>=1)
MAX_OUTSTANDING, 4, max address beats accepted but not yet returned
(local) W_ADDR=$clog2(IMG_WIDTH*IMG_HEIGHT), W_X=$clog2(IMG_WIDTH), W_Y=$clog2(IMG_HEIGHT)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start_valid  in  1  frame start request
start_ready  out  1  high in IDLE only
start_img_w  in  W_X+1  active image width for this frame
start_img_h  in  W_Y+1  active image height for this frame
start_scale  in  8  scale tag, latched at start
addr_valid  out  1  address beat valid
addr_ready  in  1  memory accepts beat
addr  out  PARALLEL_ROWS*W_ADDR  lane r = address of row y0+g*PR+r
din_valid  in  1  in-order memory return
din_ready  out  1
din_data  in  PARALLEL_ROWS*W_DATA
dout_valid  out  1
dout_ready  in  1
dout_data  out  PARALLEL_ROWS*W_DATA  equals din_data
dout_eot  out  2  [0] last column of row group, [1] last beat of window
window_pos_valid  out  1
window_pos_ready  in  1
window_pos_eot  out  1  last window of frame
window_pos_scale  out  8
window_pos_x  out  W_X  window origin x0
window_pos_y  out  W_Y  window origin y0
done  out  1  one-cycle pulse at frame end
busy  out  1  state != IDLE

Behaviour:
- Reset:
  - State is IDLE, and all counters and the credit counter are 0.
  - addr_valid, window_pos_valid, dout_valid, done and busy are 0.
  - start_ready=1 from the first cycle after rst falls.
  - Reset mid-frame aborts with no done pulse. The memory system must be reset alongside.
- FSM states are IDLE, WIN_POS, FETCH and DRAIN.
- IDLE:
  - On start handshake, latch img_w, img_h and scale; set x0=y0=0.
  - If img_w<FEATURE_WIDTH or img_h<FEATURE_HEIGHT, pulse done on the next cycle and stay in IDLE. No window is emitted.
  - Otherwise go to WIN_POS. window_pos_valid rises the next cycle.
- WIN_POS:
  - window_pos_valid=1, carrying x0, y0 and scale.
  - window_pos_eot=1 iff x0+X_STEP+FW>img_w and y0+Y_STEP+FH>img_h.
  - On handshake go to FETCH, with column c=0 and row group g=0.
- FETCH:
  - Lane r address = (y0+g*PR+r)*IMG_WIDTH + x0 + c, computed in W_ADDR bits. Addresses are registered.
  - addr_valid=1 while credit<MAX_OUTSTANDING, and holds stable until handshake.
  - Beat order: c runs fastest over 0..FW-1, then g over 0..FH/PR-1. One beat per cycle when unthrottled.
  - On the last beat's handshake:
    - If this is the last window, go to DRAIN.
    - Otherwise advance x0+=X_STEP, or if that window would not fit, x0=0 and y0+=Y_STEP; then go to WIN_POS. Next window_pos_valid is the following cycle.
- Credit counter:
  - Increments on addr handshake, decrements on din handshake; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING.
- Return path (combinational pass-through, independent of state):
  - dout_valid = din_valid & (credit!=0).
  - din_ready = dout_ready & (credit!=0).
  - A din while credit==0 is neither accepted nor forwarded.
  - The return beat counter (c_r, g_r) tags each beat: eot[0] at c_r==FW-1; eot[1] at c_r==FW-1 and g_r==FH/PR-1.
  - The return counter wraps per window, independent of the issue counters. Returns of window n may overlap address issue of window n+1.
- DRAIN: wait for credit==0, pulse done for 1 cycle, go to IDLE.
- done and window_pos_eot never assert in the same window twice. start_valid outside IDLE is ignored (start_ready=0).

Test Plan:
Use parameters IMG_WIDTH=8, IMG_HEIGHT=6, FW=FH=4, PR=2, X_STEP=Y_STEP=2, MAX_OUTSTANDING=4 unless stated; memory returns addr-derived data.
1. Start img 8x6, scale=3, all ready=1 -> 6 windows (x0,y0) = (0,0),(2,0),(4,0),(0,2),(2,2),(4,2); eot only on (4,2); scale=3 on all; 8 address beats per window; done once after the last dout.
2. Window (2,2), g=1, c=0 -> addr lanes {34,42}. Returned beats 3 and 7 of each window -> dout_eot 2'b01 and 2'b11, others 2'b00.
3. din_valid held 0 -> exactly 4 address handshakes, then addr_valid=0. Release one din -> exactly one more address is accepted.
4. Start img_w=6, img_h=4 -> windows (0,0),(2,0) only, eot on the second. Start img_w=3 -> done pulse 1 cycle after start, no window_pos_valid, no addr_valid.
5. Random addr_ready/dout_ready/window_pos_ready backpressure -> addr, window_pos and dout data stable while valid&~ready; dout stream matches the scoreboard; credit never >4.
6. rst asserted mid-FETCH -> next cycle all valids 0, busy=0, start_ready=1, no done. A new start then runs scenario 1 correctly.
